// File: rtl/video_src_switch_ctrl.sv
// Glitch-free video source switch between a test-pattern generator (s0) and a live sensor (s1).
// Switches land on frame starts only; a silent sensor forces a blanked fallback to s0.
module video_src_switch_ctrl #(
    parameter logic [23:0] LOSS_CYC = 24'd1500000
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [23:0] s0_rgb,
    input  logic        s0_de,
    input  logic        s0_hsync,
    input  logic        s0_vsync,
    input  logic [23:0] s1_rgb,
    input  logic        s1_de,
    input  logic        s1_hsync,
    input  logic        s1_vsync,
    input  logic        sel_valid,
    input  logic        sel_src,
    output logic        sel_ready,
    output logic        sel_ack,
    output logic        sel_nack,
    output logic [23:0] rgb,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        active_src,
    output logic        src1_lost
);

    typedef enum logic [1:0] {RUN, PEND, FALLBACK} state_t;
    typedef enum logic [1:0] {PICK_S0, PICK_S1, PICK_BLANK} pick_t;

    state_t      state;
    pick_t       pick;
    logic        target;
    logic [23:0] wait_cnt;
    logic [23:0] loss_cnt;
    logic        s0_vs_q;
    logic        s1_vs_q;
    logic        s0_fs;
    logic        s1_fs;
    logic        tgt_fs;
    logic        wait_done;
    logic        loss_done;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == LOSS_CYC) ? v : v + 24'd1;
    endfunction

    assign s0_fs     = ~s0_vsync & s0_vs_q;
    assign s1_fs     = ~s1_vsync & s1_vs_q;
    assign tgt_fs    = target ? s1_fs : s0_fs;
    assign wait_done = (sat_inc(wait_cnt) == LOSS_CYC);
    // A frame start in the terminal cycle resets the count, so it never counts as a loss.
    assign loss_done = (state == RUN) && active_src && !s1_fs
                       && (sat_inc(loss_cnt) == LOSS_CYC);
    assign sel_ready = (state == RUN);

    always_comb begin
        pick = active_src ? PICK_S1 : PICK_S0;
        case (state)
            PEND: begin
                if (tgt_fs) pick = target ? PICK_S1 : PICK_S0;
            end
            FALLBACK: begin
                pick = s0_fs ? PICK_S0 : PICK_BLANK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= RUN;
            target     <= 1'b0;
            active_src <= 1'b0;
            sel_ack    <= 1'b0;
            sel_nack   <= 1'b0;
            src1_lost  <= 1'b0;
            wait_cnt   <= 24'd0;
            loss_cnt   <= 24'd0;
            s0_vs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
        end else begin
            s0_vs_q  <= s0_vsync;
            s1_vs_q  <= s1_vsync;
            sel_ack  <= 1'b0;
            sel_nack <= 1'b0;

            if (s1_fs)
                loss_cnt <= 24'd0;
            else if (state == RUN && active_src)
                loss_cnt <= sat_inc(loss_cnt);

            case (state)
                RUN: begin
                    if (loss_done) begin
                        src1_lost <= 1'b1;
                        state     <= FALLBACK;
                    end else if (sel_valid) begin
                        if (sel_src == active_src) begin
                            sel_ack <= 1'b1;
                        end else begin
                            target   <= sel_src;
                            wait_cnt <= 24'd0;
                            state    <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (tgt_fs) begin
                        active_src <= target;
                        sel_ack    <= 1'b1;
                        if (target) src1_lost <= 1'b0;
                        state      <= RUN;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                        if (wait_done) begin
                            sel_nack <= 1'b1;
                            if (target) src1_lost <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                FALLBACK: begin
                    if (s0_fs) begin
                        active_src <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Output stage: one register for all four fields so a line is never torn.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rgb   <= 24'd0;
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            case (pick)
                PICK_S0: begin
                    rgb   <= s0_rgb;
                    de    <= s0_de;
                    hsync <= s0_hsync;
                    vsync <= s0_vsync;
                end
                PICK_S1: begin
                    rgb   <= s1_rgb;
                    de    <= s1_de;
                    hsync <= s1_hsync;
                    vsync <= s1_vsync;
                end
                default: begin
                    rgb   <= 24'd0;
                    de    <= 1'b0;
                    hsync <= 1'b1;
                    vsync <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/video_src_switch_ctrl.md
VIDEO_SRC_SWITCH_CTRL -- requirements
Module: video_src_switch_ctrl

Interface
REQ-001 The block SHALL have parameter LOSS_CYC, default 24'd1500000: clk cycles without a src1 frame start before src1 is declared lost; legal range 2..2^24-1.
REQ-002 The block SHALL have port clk, input, 1: single clock; both sources and all outputs are synchronous to it.
REQ-003 The block SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports s0_rgb/s0_de/s0_hsync/s0_vsync, input, 24/1/1/1: source 0, the internal test-pattern generator; syncs active-low.
REQ-005 The block SHALL have ports s1_rgb/s1_de/s1_hsync/s1_vsync, input, 24/1/1/1: source 1, the live sensor; syncs active-low.
REQ-006 The block SHALL have port sel_valid, input, 1: switch request strobe.
REQ-007 The block SHALL have port sel_src, input, 1: requested source, sampled with sel_valid.
REQ-008 The block SHALL have port sel_ready, output, 1: high only in RUN.
REQ-009 The block SHALL have ports sel_ack and sel_nack, output, 1 each: single-cycle completion pulses.
REQ-010 The block SHALL have ports rgb/de/hsync/vsync, output, 24/1/1/1: selected video, registered.
REQ-011 The block SHALL have port active_src, output, 1: source currently driving the outputs.
REQ-012 The block SHALL have port src1_lost, output, 1: sticky loss flag.

Function
REQ-013 Frame start (FS) of source n SHALL be the cycle in which sN_vsync=0 and its registered previous value=1.
REQ-014 The FSM SHALL have states RUN, PEND, FALLBACK.
REQ-015 In RUN with sel_valid=1 and sel_src==active_src, the block SHALL pulse sel_ack in the next cycle and remain in RUN.
REQ-016 In RUN with sel_valid=1 and sel_src!=active_src, the block SHALL latch target=sel_src, clear the wait counter, and enter PEND.
REQ-017 sel_valid SHALL be ignored outside RUN; it produces no ack and no nack.
REQ-018 In PEND, outputs SHALL continue from active_src.
REQ-019 On a target FS in PEND, the block SHALL set active_src=target, select target for that cycle's sample, pulse sel_ack next cycle, clear src1_lost if target=1, and return to RUN.
REQ-020 In PEND, if the wait counter reaches LOSS_CYC before a target FS, the block SHALL pulse sel_nack, leave active_src unchanged, and return to RUN.
REQ-021 If target=1, a PEND timeout SHALL also set src1_lost.
REQ-022 In RUN with active_src=1, the loss counter SHALL clear on each s1 FS and otherwise increment, saturating at LOSS_CYC.
REQ-023 When the loss counter reaches LOSS_CYC, the block SHALL set src1_lost and enter FALLBACK.
REQ-024 In FALLBACK, outputs SHALL be blanked: rgb=0, de=0, hsync=1, vsync=1.
REQ-025 On an s0 FS in FALLBACK, the block SHALL set active_src=0, output s0 from that sample, and return to RUN with no ack pulse.
REQ-026 If an s1 FS and the loss-counter terminal count occur in the same cycle, the FS SHALL take priority and no fallback SHALL occur.
REQ-027 If sel_valid arrives in the same cycle as a loss terminal count, the loss SHALL take priority and the request SHALL be dropped.
REQ-028 Output latency SHALL be exactly 1 clk from the selected input sample to rgb/de/hsync/vsync, with all four fields taken from the same source and the same cycle.
REQ-029 The counter SHALL be 24 bits and SHALL never wrap.

Reset
REQ-030 While rst_n_i=0, the block SHALL force state=RUN, active_src=0, rgb=0, de=0, hsync=1, vsync=1, sel_ack=0, sel_nack=0, src1_lost=0, counters=0, and vsync history registers=1.
REQ-031 Reset asserted mid-PEND or mid-FALLBACK SHALL abandon the operation with no ack or nack pulse.
REQ-032 After reset release, the first cycle SHALL accept sel_valid.

Verification (LOSS_CYC=100, short-frame sources)
REQ-033 Reset, then idle -> outputs equal s0 delayed 1 cycle, active_src=0, sel_ready=1.
REQ-034 sel_valid with sel_src=1, s1 FS 40 cycles later -> s0 output continues for 40 cycles, then s1 data 1 cycle after the FS, sel_ack pulse, active_src=1, no torn line.
REQ-035 sel_src=1 with s1 vsync held high -> sel_nack exactly 100 cycles later, src1_lost=1, active_src=0.
REQ-036 Active src1, then s1 vsync frozen -> after 100 cycles, outputs blanked (de=0, syncs 1, rgb=0) until the next s0 FS, then s0 output, active_src=0, src1_lost=1.
REQ-037 sel_valid with sel_src=0 while active_src=0 -> sel_ack next cycle, state unchanged; a second sel_valid during PEND -> ignored, single ack only.
REQ-038 rst_n_i pulsed low mid-PEND -> immediate reset values, no sel_ack or sel_nack pulse afterwards.
